i2c_req_arbiter: RTL and testbench

//  Shares one I2C byte engine among NREQ requesters. Each transaction is a single byte: 7-bit slave address, R/W bit and write data.

---
 rtl/i2c_req_arbiter_pkg.sv | 25 ++
 rtl/i2c_req_arbiter_if.sv | 41 ++++
 rtl/i2c_req_arbiter_rr_pick.sv | 32 +++
 rtl/i2c_req_arbiter.sv | 150 +++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : i2c_arb_pkg
// Brief   : shared widths and FSM encodings for the I2C request arbiter
// Revision: 1.0  initial release
// ============================================================================
package i2c_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        RESP  = ST_RESP
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : i2c_req_arbiter_if
// Brief   : requester-side and engine-side signals of the I2C request arbiter
// Revision: 1.0  initial release
// ============================================================================
interface i2c_req_arbiter_if #(
    parameter int NREQ = 4
);
    import i2c_arb_pkg::*;

    logic [NREQ-1:0]        iReq;
    logic [NREQ*ADDR_W-1:0] iAddr;
    logic [NREQ-1:0]        iRW;
    logic [NREQ*DATA_W-1:0] iWData;
    logic [NREQ-1:0]        oGnt;
    logic [NREQ-1:0]        oDone;
    logic [DATA_W-1:0]      oRData;
    logic                   oAckErr;
    logic                   oTimeout;
    logic                   oEngStart;
    logic [ADDR_W-1:0]      oEngAddr;
    logic                   oEngRW;
    logic [DATA_W-1:0]      oEngWData;
    logic                   iEngBusy;
    logic                   iEngDone;
    logic                   iEngAck;
    logic [DATA_W-1:0]      iEngRData;

    modport slave (
        input  iReq, iAddr, iRW, iWData, iEngBusy, iEngDone, iEngAck, iEngRData,
        output oGnt, oDone, oRData, oAckErr, oTimeout, oEngStart, oEngAddr, oEngRW, oEngWData
    );

    modport master (
        output iReq, iAddr, iRW, iWData, iEngBusy, iEngDone, iEngAck, iEngRData,
        input  oGnt, oDone, oRData, oAckErr, oTimeout, oEngStart, oEngAddr, oEngRW, oEngWData
    );

endinterface
`default_nettype wire

// File: rtl/i2c_req_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : combinational round-robin picker, first set bit after ptr (wrapping)
// Revision: 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  wire logic [NREQ-1:0]  req,
    input  wire logic [PTR_W-1:0] ptr,
    output logic                  any,
    output logic [PTR_W-1:0]      idx
);

    // Scan farthest candidate first so the nearest one after ptr overwrites it.
    always_comb begin
        logic [PTR_W-1:0] wCand;
        wCand = '0;
        idx   = '0;
        any   = |req;
        for (int k = NREQ; k >= 1; k--) begin
            wCand = PTR_W'((int'(ptr) + k) % NREQ);
            if (req[wCand]) begin
                idx = wCand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : i2c_req_arbiter
// Brief   : round-robin sharing of one I2C byte engine among NREQ requesters
// Revision: 1.0  initial release
// ============================================================================
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter  int NREQ        = 4,
    parameter  int TIMEOUT_CYC = 4096,
    localparam int TMR_W       = $clog2(TIMEOUT_CYC)
) (
    input  wire logic        CLK,
    input  wire logic        Reset,
    i2c_req_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NREQ);

    arb_state_t        rState;
    arb_state_t        wNextState;
    logic [PTR_W-1:0]  rPtr;
    logic [PTR_W-1:0]  rIdx;
    logic [PTR_W-1:0]  wPick;
    logic              wAny;
    logic              wLatch;
    logic              wStart;
    logic              wCapDone;
    logic              wCapTo;
    logic [TMR_W-1:0]  rTmr;
    logic [ADDR_W-1:0] rAddr;
    logic              rRW;
    logic [DATA_W-1:0] rWData;
    logic [DATA_W-1:0] rRData;
    logic              rAckErr;
    logic              rTimeout;
    logic [NREQ-1:0]   wOneHot;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req (bus.iReq),
        .ptr (rPtr),
        .any (wAny),
        .idx (wPick)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rState <= IDLE;
        end else begin
            rState <= wNextState;
        end
    end

    always_comb begin
        wNextState = rState;
        wLatch     = 1'b0;
        wStart     = 1'b0;
        wCapDone   = 1'b0;
        wCapTo     = 1'b0;
        case (rState)
            IDLE: begin
                if (wAny) begin
                    wLatch     = 1'b1;
                    wNextState = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.iEngBusy) begin
                    wStart     = 1'b1;
                    wNextState = WAIT;
                end
            end
            WAIT: begin
                // A completion in the final timer cycle still counts as a real completion.
                if (bus.iEngDone) begin
                    wCapDone   = 1'b1;
                    wNextState = RESP;
                end else if (rTmr == TMR_W'(TIMEOUT_CYC - 1)) begin
                    wCapTo     = 1'b1;
                    wNextState = RESP;
                end
            end
            RESP:    wNextState = IDLE;
            default: wNextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rPtr     <= PTR_W'(NREQ - 1);
            rIdx     <= '0;
            rAddr    <= '0;
            rRW      <= 1'b0;
            rWData   <= '0;
            rTmr     <= '0;
            rRData   <= '0;
            rAckErr  <= 1'b0;
            rTimeout <= 1'b0;
        end else begin
            if (wLatch) begin
                rIdx   <= wPick;
                rAddr  <= ADDR_W'(bus.iAddr >> (int'(wPick) * ADDR_W));
                rRW    <= bus.iRW[wPick];
                rWData <= DATA_W'(bus.iWData >> (int'(wPick) * DATA_W));
            end
            if (wStart) begin
                rTmr <= '0;
            end else if (rState == WAIT && !bus.iEngDone) begin
                rTmr <= rTmr + 1'b1;
            end
            if (wCapDone) begin
                rRData   <= bus.iEngRData;
                rAckErr  <= ~bus.iEngAck;
                rTimeout <= 1'b0;
            end else if (wCapTo) begin
                rRData   <= '0;
                rAckErr  <= 1'b0;
                rTimeout <= 1'b1;
            end else if (rState == RESP) begin
                rRData   <= '0;
                rAckErr  <= 1'b0;
                rTimeout <= 1'b0;
            end
            if (rState == RESP) begin
                rPtr <= rIdx;
            end
        end
    end

    always_comb begin
        wOneHot       = '0;
        wOneHot[rIdx] = 1'b1;
    end

    assign bus.oGnt      = (rState == IDLE) ? '0 : wOneHot;
    assign bus.oDone     = (rState == RESP) ? wOneHot : '0;
    assign bus.oRData    = rRData;
    assign bus.oAckErr   = rAckErr;
    assign bus.oTimeout  = rTimeout;
    assign bus.oEngStart = wStart;
    assign bus.oEngAddr  = rAddr;
    assign bus.oEngRW    = rRW;
    assign bus.oEngWData = rWData;

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2c_req_arbiter
// Brief   : scoreboard bench for i2c_req_arbiter with a cycle-level reference model
// Revision: 1.0  initial release
// ============================================================================
module tb_i2c_req_arbiter;
    import i2c_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int T    = 16;
    localparam int AW   = NREQ * 7;
    localparam int DW   = NREQ * 8;

    logic CLK   = 1'b0;
    logic Reset = 1'b0;
    int   cyc   = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    i2c_req_arbiter_if #(.NREQ(NREQ)) bus ();

    i2c_req_arbiter #(
        .NREQ        (NREQ),
        .TIMEOUT_CYC (T)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        int         g;
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
    } start_t;

    typedef struct {
        int         cyc;
        int         g;
        logic [6:0] addr;
        logic [7:0] rdata;
        logic       ackErr;
        logic       timeout;
    } done_t;

    start_t expStart[$];
    done_t  expDone[$];
    int     checks = 0;
    int     errors = 0;
    int     ptr    = NREQ - 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round robin: first requesting index strictly after the last winner, wrapping.
    function automatic int pickModel(input logic [NREQ-1:0] m);
        int i;
        for (int k = 1; k <= NREQ; k++) begin
            i = (ptr + k) % NREQ;
            if (((int'(m) >> i) & 1) == 1) return i;
        end
        return -1;
    endfunction

    task automatic gotoCycle(input int k);
        while (cyc < k) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic checkQuiet(input string tag);
        chk({tag, ".gnt"},   32'(bus.oGnt), 0);
        chk({tag, ".done"},  32'(bus.oDone), 0);
        chk({tag, ".start"}, 32'(bus.oEngStart), 0);
        chk({tag, ".eng"},   {16'h0, bus.oEngAddr, bus.oEngRW, bus.oEngWData}, 0);
        chk({tag, ".resp"},  {22'h0, bus.oRData, bus.oAckErr, bus.oTimeout}, 0);
    endtask

    task automatic randVecs(output logic [AW-1:0] a, output logic [NREQ-1:0] rw,
                            output logic [DW-1:0] wd);
        a  = AW'({$urandom, $urandom});
        rw = NREQ'($urandom);
        wd = DW'({$urandom, $urandom});
    endtask

    // Called in a cycle where the arbiter is idle; returns in the idle cycle after oDone.
    // dly: engine done this many cycles after start (0 = never); abortAt > 0 resets mid-WAIT.
    task automatic doTxn(input logic [NREQ-1:0] mask, input logic [AW-1:0] addrV,
                         input logic [NREQ-1:0] rwV, input logic [DW-1:0] wdV,
                         input int busyN, input int dly, input logic ack,
                         input logic [7:0] rdata, input bit drop, input bit spur,
                         input int abortAt);
        int     c, g, s, r;
        bit     to;
        start_t es;
        done_t  ed;
        c            = cyc;
        bus.iReq     = mask;
        bus.iAddr    = addrV;
        bus.iRW      = rwV;
        bus.iWData   = wdV;
        bus.iEngBusy = (busyN > 0);
        if (spur) begin
            bus.iEngDone  = 1'b1;
            bus.iEngAck   = 1'($urandom);
            bus.iEngRData = 8'($urandom);
        end
        g  = pickModel(mask);
        to = (dly == 0) || (dly > T);
        s  = c + 1 + busyN;
        r  = s + (to ? T : dly) + 1;
        es.cyc     = s;
        es.g       = g;
        es.addr    = 7'(addrV >> (g * 7));
        es.rw      = 1'(rwV >> g);
        es.wdata   = 8'(wdV >> (g * 8));
        ed.cyc     = r;
        ed.g       = g;
        ed.addr    = es.addr;
        ed.rdata   = to ? 8'h00 : rdata;
        ed.ackErr  = to ? 1'b0 : ~ack;
        ed.timeout = to;
        expStart.push_back(es);
        expDone.push_back(ed);
        ptr = g;

        gotoCycle(c + 1);
        bus.iEngDone = 1'b0;
        if (drop) begin
            bus.iReq   = '0;
            bus.iAddr  = ~addrV;
            bus.iRW    = ~rwV;
            bus.iWData = ~wdV;
        end
        if (busyN > 0) begin
            gotoCycle(c + 1 + busyN);
            bus.iEngBusy = 1'b0;
        end
        if (abortAt > 0) begin
            gotoCycle(s + abortAt);
            bus.iReq = '0;
            #2 Reset = 1'b0;
            #1 checkQuiet("abortReset");
            ed  = expDone.pop_back();
            ptr = NREQ - 1;
            @(posedge CLK);
            #1 Reset = 1'b1;
            return;
        end
        if (dly > 0 && dly <= T + 1) begin
            gotoCycle(s + dly);
            bus.iEngDone  = 1'b1;
            bus.iEngAck   = ack;
            bus.iEngRData = rdata;
            gotoCycle(s + dly + 1);
            bus.iEngDone  = 1'b0;
            bus.iEngAck   = 1'b0;
            bus.iEngRData = 8'h00;
        end
        gotoCycle(r + 1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a start or a completion.
    initial begin
        start_t es;
        done_t  ed;
        forever begin
            @(negedge CLK);
            if (Reset) begin
                if (bus.oEngStart) begin
                    if (expStart.size() == 0) begin
                        chk("spuriousStart", 32'(bus.oEngStart), 0);
                    end else begin
                        es = expStart.pop_front();
                        chk("startCycle", cyc, es.cyc);
                        chk("startGnt",   32'(bus.oGnt), 32'(1 << es.g));
                        chk("engAddr",    32'(bus.oEngAddr), 32'(es.addr));
                        chk("engRW",      32'(bus.oEngRW), 32'(es.rw));
                        chk("engWData",   32'(bus.oEngWData), 32'(es.wdata));
                    end
                end
                if (bus.oDone != '0) begin
                    if (expDone.size() == 0) begin
                        chk("spuriousDone", 32'(bus.oDone), 0);
                    end else begin
                        ed = expDone.pop_front();
                        chk("doneCycle",   cyc, ed.cyc);
                        chk("doneMask",    32'(bus.oDone), 32'(1 << ed.g));
                        chk("doneGnt",     32'(bus.oGnt), 32'(1 << ed.g));
                        chk("doneRData",   32'(bus.oRData), 32'(ed.rdata));
                        chk("doneAckErr",  32'(bus.oAckErr), 32'(ed.ackErr));
                        chk("doneTimeout", 32'(bus.oTimeout), 32'(ed.timeout));
                        chk("doneEngAddr", 32'(bus.oEngAddr), 32'(ed.addr));
                    end
                end else begin
                    chk("quietResp", {22'h0, bus.oRData, bus.oAckErr, bus.oTimeout}, 0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [AW-1:0]   a;
        logic [NREQ-1:0] rw;
        logic [DW-1:0]   wd;
        logic [NREQ-1:0] m;
        int              b, d;

        bus.iReq      = '0;
        bus.iAddr     = '0;
        bus.iRW       = '0;
        bus.iWData    = '0;
        bus.iEngBusy  = 1'b0;
        bus.iEngDone  = 1'b0;
        bus.iEngAck   = 1'b0;
        bus.iEngRData = 8'h00;

        repeat (3) @(posedge CLK);
        #1 checkQuiet("reset");
        Reset = 1'b1;

        // Single write from requester 0, acked.
        randVecs(a, rw, wd);
        a[6:0]  = 7'h50;
        rw[0]   = 1'b0;
        wd[7:0] = 8'hA5;
        doTxn(4'b0001, a, rw, wd, 0, 10, 1'b1, 8'h00, 0, 0, 0);

        // Read from requester 1, slave NACKs.
        randVecs(a, rw, wd);
        rw[1] = 1'b1;
        doTxn(4'b0010, a, rw, wd, 0, 6, 1'b0, 8'h3C, 0, 0, 0);

        // All requesters held for 8 back-to-back transactions.
        for (int i = 0; i < 8; i++) begin
            randVecs(a, rw, wd);
            doTxn(4'b1111, a, rw, wd, 0, 1 + int'($urandom_range(0, 3)),
                  1'($urandom), 8'($urandom), 0, 0, 0);
        end

        // Engine never completes; done on the last timer cycle; done while in RESP.
        randVecs(a, rw, wd);
        doTxn(4'b0001, a, rw, wd, 0, 0, 1'b1, 8'h11, 0, 0, 0);
        randVecs(a, rw, wd);
        doTxn(4'b1000, a, rw, wd, 0, T, 1'b1, 8'h77, 0, 0, 0);
        randVecs(a, rw, wd);
        doTxn(4'b0100, a, rw, wd, 0, T + 1, 1'b0, 8'h99, 0, 0, 0);

        // Engine busy for 5 cycles in ISSUE.
        randVecs(a, rw, wd);
        doTxn(4'b0100, a, rw, wd, 5, 3, 1'b1, 8'h5A, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            randVecs(a, rw, wd);
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            b = int'($urandom_range(0, 3));
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, T + 1));
            doTxn(m, a, rw, wd, b, d, 1'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 0);
        end

        // Reset in WAIT abandons the transaction; requester 0 then wins first.
        randVecs(a, rw, wd);
        doTxn(4'b0100, a, rw, wd, 0, 4, 1'b1, 8'h00, 0, 0, 0);
        randVecs(a, rw, wd);
        doTxn(4'b1010, a, rw, wd, 0, 0, 1'b1, 8'h00, 0, 0, 3);
        randVecs(a, rw, wd);
        doTxn(4'b1111, a, rw, wd, 0, 2, 1'b1, 8'hC3, 0, 0, 0);

        bus.iReq = '0;
        repeat (6) @(posedge CLK);
        #1;
        chk("pendingStart", 32'(expStart.size()), 0);
        chk("pendingDone",  32'(expDone.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
